// File: rtl/td4_sequencer_if.sv
// Control bundle between the TD4 sequencer, program ROM/run control and the register file.
// master = sequencer side, slave = datapath/ROM side.
interface td4_sequencer_if;
    logic       run;
    logic [7:0] instr;
    logic       c_flag_n;
    logic       fetch;
    logic [7:0] ir;
    logic [1:0] sel;
    logic [3:0] ld_n;
    logic       reg_en;
    logic       flag_en;
    logic       busy;
    logic       illegal;
    logic [1:0] state;

    modport master (
        input  run, instr, c_flag_n,
        output fetch, ir, sel, ld_n, reg_en, flag_en, busy, illegal, state
    );

    modport slave (
        output run, instr, c_flag_n,
        input  fetch, ir, sel, ld_n, reg_en, flag_en, busy, illegal, state
    );
endinterface

// File: rtl/td4_sequencer.sv
// Fetch/decode/execute controller for the 4-bit TD4 datapath.
// Optional TD4_SINGLE_STEP_EN adds step_req/step_ack for one-instruction stepping.
module td4_sequencer #(
    parameter int unsigned ROM_WAIT = 0
) (
    input  logic CLK,
    input  logic CLR,
`ifdef TD4_SINGLE_STEP_EN
    input  logic step_req,
    output logic step_ack,
`endif
    td4_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StFetch  = 2'b01,
        StDecode = 2'b10,
        StExec   = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] ir_q, ir_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] ld_n_q, ld_n_d;
    logic       ill_q, ill_d;
    logic [1:0] dec_sel;
    logic [3:0] dec_ld_n;
    logic       dec_ill;
    logic       start;

    // Decode is combinational on ir_q; the result is frozen into *_q at the end of DECODE
    // so EXEC sees exactly what DECODE set up, including the JNC flag decision.
    always_comb begin
        dec_sel  = 2'b11;
        dec_ld_n = 4'b1111;
        dec_ill  = 1'b0;
        case (ir_q[7:4])
            4'b0000: begin dec_sel = 2'b00; dec_ld_n = 4'b1110; end
            4'b0101: begin dec_sel = 2'b01; dec_ld_n = 4'b1101; end
            4'b0011: begin dec_sel = 2'b11; dec_ld_n = 4'b1110; end
            4'b0111: begin dec_sel = 2'b11; dec_ld_n = 4'b1101; end
            4'b0001: begin dec_sel = 2'b01; dec_ld_n = 4'b1110; end
            4'b0100: begin dec_sel = 2'b00; dec_ld_n = 4'b1101; end
            4'b0010: begin dec_sel = 2'b10; dec_ld_n = 4'b1110; end
            4'b0110: begin dec_sel = 2'b10; dec_ld_n = 4'b1101; end
            4'b1001: begin dec_sel = 2'b01; dec_ld_n = 4'b1011; end
            4'b1011: begin dec_sel = 2'b11; dec_ld_n = 4'b1011; end
            4'b1111: begin dec_sel = 2'b11; dec_ld_n = 4'b0111; end
            4'b1110: begin
                dec_sel  = 2'b11;
                dec_ld_n = bus.c_flag_n ? 4'b0111 : 4'b1111;
            end
            default: dec_ill = 1'b1;
        endcase
    end

`ifdef TD4_SINGLE_STEP_EN
    logic step_arm_q, step_arm_d;
    logic step_act_q, step_act_d;

    assign start    = bus.run | (step_req & step_arm_q);
    assign step_ack = (state_q == StExec) & step_act_q;

    // A step needs step_req to have been seen low since the last accepted step.
    always_comb begin
        step_arm_d = step_arm_q | ~step_req;
        step_act_d = step_act_q;
        if (state_q == StIdle && !bus.run && step_req && step_arm_q) begin
            step_arm_d = 1'b0;
            step_act_d = 1'b1;
        end else if (state_q == StExec) begin
            step_act_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            step_arm_q <= 1'b0;
            step_act_q <= 1'b0;
        end else begin
            step_arm_q <= step_arm_d;
            step_act_q <= step_act_d;
        end
    end
`else
    assign start = bus.run;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        sel_d   = sel_q;
        ld_n_d  = ld_n_q;
        ill_d   = ill_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                if (cnt_q == 4'(ROM_WAIT)) begin
                    ir_d    = bus.instr;
                    cnt_d   = 4'd0;
                    state_d = StDecode;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDecode: begin
                sel_d   = dec_sel;
                ld_n_d  = dec_ld_n;
                ill_d   = dec_ill;
                state_d = StExec;
            end
            StExec: begin
                state_d = bus.run ? StFetch : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            ir_q    <= 8'h00;
            sel_q   <= 2'b00;
            ld_n_q  <= 4'b1111;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            sel_q   <= sel_d;
            ld_n_q  <= ld_n_d;
            ill_q   <= ill_d;
        end
    end

    // Strobes decode straight from state_q so CLR kills them in the same cycle.
    always_comb begin
        bus.fetch   = (state_q == StFetch);
        bus.busy    = (state_q != StIdle);
        bus.reg_en  = (state_q == StExec);
        bus.flag_en = (state_q == StExec);
        bus.illegal = (state_q == StExec) & ill_q;
        bus.ir      = ir_q;
        bus.state   = state_q;
        bus.sel     = 2'b00;
        bus.ld_n    = 4'b1111;
        if (state_q == StDecode) begin
            bus.sel  = dec_sel;
            bus.ld_n = dec_ld_n;
        end else if (state_q == StExec) begin
            bus.sel  = sel_q;
            bus.ld_n = ld_n_q;
        end
    end

endmodule

// File: tb/tb_td4_sequencer.sv
// Scoreboard bench for td4_sequencer: ROM_WAIT=0 instance for decode/flow,
// ROM_WAIT=3 instance for FETCH stretching.
module tb_td4_sequencer;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       run0, cfn0, run3;
    logic [7:0] instr0;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [7:0] ir;
        logic [3:0] ld_n;
        logic [1:0] sel;
        logic       ill;
    } exp_t;

    exp_t sb[$];

    td4_sequencer_if if0();
    td4_sequencer_if if3();

    assign if0.run      = run0;
    assign if0.instr    = instr0;
    assign if0.c_flag_n = cfn0;
    assign if3.run      = run3;
    assign if3.instr    = 8'h00;
    assign if3.c_flag_n = 1'b1;

`ifdef TD4_SINGLE_STEP_EN
    logic step_req = 1'b0;
    logic step_ack0, step_ack3;
`endif

    td4_sequencer #(.ROM_WAIT(0)) u_dut0 (
        .CLK      (CLK),
        .CLR      (CLR),
`ifdef TD4_SINGLE_STEP_EN
        .step_req (step_req),
        .step_ack (step_ack0),
`endif
        .bus      (if0)
    );

    td4_sequencer #(.ROM_WAIT(3)) u_dut3 (
        .CLK      (CLK),
        .CLR      (CLR),
`ifdef TD4_SINGLE_STEP_EN
        .step_req (step_req),
        .step_ack (step_ack3),
`endif
        .bus      (if3)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode taken from the opcode table: returns {ill, sel, ld_n}.
    function automatic logic [6:0] ref_dec(input logic [7:0] i, input logic cfn);
        case (i[7:4])
            4'h0: return {1'b0, 2'b00, 4'b1110};
            4'h5: return {1'b0, 2'b01, 4'b1101};
            4'h3: return {1'b0, 2'b11, 4'b1110};
            4'h7: return {1'b0, 2'b11, 4'b1101};
            4'h1: return {1'b0, 2'b01, 4'b1110};
            4'h4: return {1'b0, 2'b00, 4'b1101};
            4'h2: return {1'b0, 2'b10, 4'b1110};
            4'h6: return {1'b0, 2'b10, 4'b1101};
            4'h9: return {1'b0, 2'b01, 4'b1011};
            4'hB: return {1'b0, 2'b11, 4'b1011};
            4'hF: return {1'b0, 2'b11, 4'b0111};
            4'hE: return {1'b0, 2'b11, (cfn ? 4'b0111 : 4'b1111)};
            default: return {1'b1, 2'b00, 4'b1111};
        endcase
    endfunction

    // Wait for dut0 to enter FETCH, then present the instruction and log its expectation.
    task automatic issue(input logic [7:0] i, input logic cfn);
        int   n = 0;
        exp_t e;
        logic [6:0] d;
        do begin
            @(posedge CLK);
            #2;
            n++;
        end while (if0.state != 2'b01 && n < 20);
        if (if0.state != 2'b01) begin
            check_eq("fetch_wait", if0.state, 2'b01);
            return;
        end
        instr0 = i;
        cfn0   = cfn;
        d      = ref_dec(i, cfn);
        e.ir   = i;
        e.ill  = d[6];
        e.sel  = d[5:4];
        e.ld_n = d[3:0];
        sb.push_back(e);
    endtask

    logic prev_exec = 1'b0;
    logic prev_run  = 1'b0;

    always @(negedge CLK) begin
        exp_t e;
        if (!CLR) begin
            prev_exec = 1'b0;
        end else begin
            if (prev_exec) check_eq("next_state", if0.state, prev_run ? 2'b01 : 2'b00);
            if (if0.state == 2'b11) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check_eq("exec_ir", if0.ir, e.ir);
                    check_eq("exec_ld_n", if0.ld_n, e.ld_n);
                    if (!e.ill) check_eq("exec_sel", if0.sel, e.sel);
                    check_eq("exec_illegal", if0.illegal, e.ill);
                    check_eq("exec_strobes", {if0.reg_en, if0.flag_en, if0.fetch, if0.busy},
                             4'b1101);
                end
            end else begin
                check_eq("quiet_strobes", {if0.reg_en, if0.flag_en, if0.illegal}, 3'b000);
                if (if0.state != 2'b10) check_eq("quiet_ld_n", if0.ld_n, 4'b1111);
            end
            prev_exec = (if0.state == 2'b11);
            prev_run  = if0.run;
        end
    end

    initial begin
        int n;
        CLR    = 1'b0;
        run0   = 1'b0;
        run3   = 1'b0;
        cfn0   = 1'b1;
        instr0 = 8'h00;
        #12;
        check_eq("rst_state", if0.state, 2'b00);
        check_eq("rst_ir", if0.ir, 8'h00);
        check_eq("rst_ld_n", if0.ld_n, 4'b1111);
        check_eq("rst_sel", if0.sel, 2'b00);
        check_eq("rst_strobes", {if0.reg_en, if0.flag_en, if0.fetch, if0.busy, if0.illegal},
                 5'b0);

        @(negedge CLK);
        CLR  = 1'b1;
        run0 = 1'b1;
        issue(8'h35, 1'b1);
        issue(8'hE7, 1'b1);
        issue(8'hE7, 1'b0);
        issue(8'h8A, 1'b1);
        issue(8'h12, 1'b0);
        issue(8'h4F, 1'b1);
        issue(8'h25, 1'b1);
        issue(8'h61, 1'b0);
        issue(8'h59, 1'b1);
        issue(8'h73, 1'b1);
        issue(8'h0C, 1'b0);
        issue(8'h9F, 1'b1);
        issue(8'hB3, 1'b1);
        issue(8'hF2, 1'b0);
        issue(8'hA0, 1'b1);
        issue(8'hC1, 1'b1);
        issue(8'hD5, 1'b0);
        for (int k = 0; k < 24; k++) begin
            issue(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        // Drop run during DECODE of OUT B: it must still execute, then go idle.
        issue(8'h90, 1'b1);
        @(posedge CLK);
        #2;
        check_eq("drop_in_decode", if0.state, 2'b10);
        run0 = 1'b0;
        @(posedge CLK);
        #2;
        @(posedge CLK);
        #2;
        check_eq("drop_idle_state", if0.state, 2'b00);
        check_eq("drop_busy", if0.busy, 1'b0);
        repeat (3) @(posedge CLK);
        #2;
        check_eq("stay_idle", if0.state, 2'b00);
        check_eq("sb_drain", sb.size(), 0);

        // ROM_WAIT=3: FETCH spans 4 cycles, instruction period 6.
        @(negedge CLK);
        run3 = 1'b1;
        n = 0;
        while (!if3.fetch && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check_eq("w3_fetch_seen", if3.fetch, 1'b1);
        n = 0;
        while (if3.fetch && n < 20) begin
            n++;
            @(negedge CLK);
        end
        check_eq("w3_fetch_len", n, 4);
        check_eq("w3_decode", if3.state, 2'b10);
        while (!if3.fetch && n < 20) begin
            n++;
            @(negedge CLK);
        end
        check_eq("w3_period", n, 6);
        run3 = 1'b0;
        repeat (8) @(negedge CLK);
        check_eq("w3_idle", if3.state, 2'b00);

        // Asynchronous CLR in the middle of FETCH.
        run0 = 1'b1;
        n = 0;
        do begin
            @(posedge CLK);
            #2;
            n++;
        end while (if0.state != 2'b01 && n < 20);
        check_eq("pre_clr_fetch", if0.state, 2'b01);
        #1;
        CLR = 1'b0;
        #1;
        check_eq("clr_state", if0.state, 2'b00);
        check_eq("clr_ld_n", if0.ld_n, 4'b1111);
        check_eq("clr_reg_en", if0.reg_en, 1'b0);
        check_eq("clr_fetch", if0.fetch, 1'b0);
        sb.delete();
        repeat (3) @(posedge CLK);
        #2;
        check_eq("clr_hold", {if0.state, if0.reg_en, if0.flag_en}, 4'b0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
